// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction memory loader.
// State encoding and stream framing sizes.
package imem_loader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LEN_LO,
    LEN_HI,
    DATA,
    DONE,
    ERR
  } state_t;

  localparam int HDR_BYTES  = 2;
  localparam int WORD_BYTES = 4;

endpackage

// File: rtl/loader_word_assembler.sv
// Packs incoming stream bytes into 32-bit words, LSB lane first.
// word_complete marks the transfer that supplies the top lane.
module loader_word_assembler
  import imem_loader_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        byte_en,
  input  logic [7:0]  byte_data,
  output logic [31:0] word,
  output logic        word_complete
);

  logic [1:0]  byte_idx;
  logic [23:0] lanes;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      byte_idx <= '0;
      lanes    <= '0;
    end else if (byte_en) begin
      case (byte_idx)
        2'd0:    lanes[7:0]   <= byte_data;
        2'd1:    lanes[15:8]  <= byte_data;
        2'd2:    lanes[23:16] <= byte_data;
        default: ;
      endcase
      byte_idx <= byte_idx + 2'd1;
    end
  end

  // The top lane is never stored; the word is complete as it arrives.
  assign word          = {byte_data, lanes};
  assign word_complete = byte_en && (byte_idx == 2'(WORD_BYTES - 1));

endmodule

// File: rtl/imem_loader.sv
// Write side of the instruction memory: streams a length-prefixed
// program into imem while holding the CPU stalled.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          DEPTH_WORDS = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic        byte_ready,
  output logic        wr_en,
  output logic [31:0] wr_addr,
  output logic [31:0] wr_data,
  output logic        cpu_hold,
  output logic        busy,
  output logic        done,
  output logic        error
);

  state_t      state, state_nx;
  logic [15:0] count;
  logic [15:0] word_idx;
  logic        last_pending;
  logic        xfer;
  logic [15:0] full_count;
  logic [31:0] word;
  logic        word_complete;

  assign xfer       = byte_valid && byte_ready;
  assign full_count = {byte_data, count[7:0]};

  loader_word_assembler u_asm (
    .clk           (clk),
    .reset         (reset),
    .clear         (state != DATA),
    .byte_en       (xfer && (state == DATA)),
    .byte_data     (byte_data),
    .word          (word),
    .word_complete (word_complete)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:   if (start) state_nx = LEN_LO;
      LEN_LO: if (xfer)  state_nx = LEN_HI;
      LEN_HI: begin
        if (xfer) begin
          if (full_count == 16'd0)
            state_nx = DONE;
          else if (full_count > 16'(DEPTH_WORDS))
            state_nx = ERR;
          else
            state_nx = DATA;
        end
      end
      DATA:   if (last_pending) state_nx = DONE;
      DONE:   if (start) state_nx = LEN_LO;
      ERR:    if (start) state_nx = LEN_LO;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    byte_ready = 1'b0;
    busy       = 1'b0;
    cpu_hold   = 1'b0;
    done       = 1'b0;
    error      = 1'b0;
    unique case (state)
      LEN_LO, LEN_HI: begin
        byte_ready = 1'b1;
        busy       = 1'b1;
        cpu_hold   = 1'b1;
      end
      DATA: begin
        byte_ready = !last_pending;
        busy       = 1'b1;
        cpu_hold   = 1'b1;
      end
      DONE: done = 1'b1;
      ERR: begin
        byte_ready = 1'b1;
        cpu_hold   = 1'b1;
        error      = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count        <= '0;
      word_idx     <= '0;
      last_pending <= 1'b0;
      wr_en        <= 1'b0;
      wr_addr      <= BASE_ADDR;
      wr_data      <= '0;
    end else begin
      wr_en        <= 1'b0;
      last_pending <= 1'b0;
      if (state == LEN_LO && xfer) count[7:0]  <= byte_data;
      if (state == LEN_HI && xfer) count[15:8] <= byte_data;
      if (state == LEN_HI) word_idx <= '0;
      if (state == DATA && word_complete) begin
        wr_en        <= 1'b1;
        wr_data      <= word;
        wr_addr      <= BASE_ADDR + 32'(word_idx) * 32'(WORD_BYTES);
        word_idx     <= word_idx + 16'd1;
        last_pending <= (word_idx == count - 16'd1);
      end
    end
  end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Program loader: the write side of the instruction memory, which the CPU fetch path only reads.
- Accepts a byte stream over a valid/ready handshake: 16-bit word count, then instruction words, least-significant byte first.
- Assembles 32-bit words and writes them at sequential word addresses on an imem write port.
- Holds the CPU stalled while loading and reports done or error.

Parameters:
- BASE_ADDR, 32'h0000_0000, byte address of the first word written; word-aligned.
- DEPTH_WORDS, 64, imem capacity in words; a larger header count is an error.

Ports:
- clk  input  1  system clock; all state on rising edge
- reset  input  1  synchronous, active-high reset
- start  input  1  one-cycle pulse; begins a load session
- byte_valid  input  1  byte_data holds a byte
- byte_data  input  8  stream byte
- byte_ready  output  1  loader can accept a byte this cycle
- wr_en  output  1  one-cycle imem write strobe
- wr_addr  output  32  imem byte address, word-aligned
- wr_data  output  32  instruction word
- cpu_hold  output  1  keep CPU stalled / in reset
- busy  output  1  session in progress
- done  output  1  load completed successfully (level)
- error  output  1  header count exceeded DEPTH_WORDS (level)

Behaviour:
- Reset values: byte_ready, wr_en, cpu_hold, busy, done, error = 0; wr_addr = BASE_ADDR; wr_data = 0; FSM = IDLE; all counters 0.
- Byte transfer occurs only on a cycle where byte_valid && byte_ready. byte_data is ignored otherwise. Gaps in byte_valid of any length are legal.
- States:
  - IDLE: byte_ready=0. On start go to LEN_LO; set busy=1 and cpu_hold=1.
  - LEN_LO: byte_ready=1. On transfer, capture count[7:0] and go to LEN_HI.
  - LEN_HI: byte_ready=1. On transfer, capture count[15:8] and evaluate the full count:
    - count==0 -> DONE; no writes.
    - count>DEPTH_WORDS -> ERR.
    - otherwise -> DATA, with word_idx=0 and byte_idx=0.
  - DATA: byte_ready=1.
    - On transfer, the byte goes into word lane byte_idx: byte 0 to bits 7:0, byte 3 to bits 31:24. byte_idx then increments modulo 4.
    - On the transfer with byte_idx==3, the next cycle drives wr_en=1 for exactly one cycle, with wr_data = assembled word and wr_addr = BASE_ADDR + 4*word_idx. word_idx then increments.
    - After the write of word count-1, go to DONE in the cycle following the wr_en pulse.
    - byte_ready stays 1 during that pulse unless it is the last word.
  - DONE: byte_ready=0, busy=0, cpu_hold=0, done=1. A start pulse re-enters LEN_LO, clearing done.
  - ERR: busy=0, cpu_hold=1, error=1, byte_ready=1. Incoming bytes are accepted and discarded so upstream cannot deadlock. No writes ever occur. A start pulse re-enters LEN_LO, clearing error.
- start is ignored in LEN_LO, LEN_HI and DATA.
- wr_addr and wr_data hold their last values when wr_en=0.
- Latency: last byte of a word accepted at cycle t -> wr_en at t+1. Last word's wr_en at t+1 -> done=1 at t+2.
- Throughput: one byte per cycle sustained. A 4-byte word needs at least 4 cycles.
- Reset mid-session: returns to IDLE immediately. Any partial word is dropped, no wr_en is issued, and cpu_hold drops.
- Arithmetic: count is 16-bit unsigned. word_idx is 16-bit. wr_addr is computed in 32 bits, with wrap-around ignored because DEPTH_WORDS bounds it.

Decomposition:
- Shared package holds:
  - the state enum (IDLE, LEN_LO, LEN_HI, DATA, DONE, ERR);
  - the header length constant (2 bytes);
  - the word-bytes constant (4).
- One natural sub-module, loader_word_assembler: shift/lane register with byte_idx counter and word_complete pulse.
- FSM, counters and address generation stay in imem_loader.

Test Plan:
- Normal load: start; bytes 02 00 78 56 34 12 EF BE AD DE, back-to-back.
  -> Exactly two wr_en pulses: addr 0x0 data 0x12345678, then addr 0x4 data 0xDEADBEEF.
  -> done=1 two cycles after the last byte; cpu_hold falls with it.
- Gapped stream: same bytes with byte_valid low for 3 cycles between each byte.
  -> Identical writes.
  -> byte_ready never blocks a valid byte.
- Zero count: start; bytes 00 00.
  -> No wr_en; done=1 the cycle after the second byte.
- Overflow: start; bytes 41 00 (65 > 64), then 8 further bytes.
  -> error=1 and cpu_hold=1; all bytes accepted; zero wr_en.
  -> A new start with a valid stream loads correctly.
- Reset mid-word: start; 01 00 AA BB; assert reset one cycle.
  -> All outputs at reset values; no wr_en.
  -> A subsequent start with 01 00 11 22 33 44 writes 0x44332211 at addr 0x0.
- start pulsed while in DATA -> ignored; the load completes with the original count.
